// File: rtl/rou_injector.sv
// Local-master injection stage for a rou_switch2 input: in-order request FIFO,
// ring-bus message packing, read-credit limiting and sticky error reporting.
module rou_injector #(
   parameter int unsigned DWID  = 128,
   parameter int unsigned AWID  = 32,
   parameter int unsigned TWID  = 5,
   parameter int unsigned BWID  = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                                  (DWID == 128) ? 4 : (DWID == 64)  ? 3 : 2,
   parameter int unsigned WID   = 2 + DWID + AWID + BWID + TWID,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned MAXRD = 4,
   parameter int unsigned TMO   = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     softreset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_cmd,
   input  logic [TWID-1:0]          req_target,
   input  logic [AWID-1:0]          req_addr,
   input  logic [BWID-1:0]          req_size,
   input  logic [DWID-1:0]          req_data,
   output logic [WID-1:0]           rou_out,
   output logic                     rou_out_seen,
   input  logic [2:0]               ack_out,
   input  logic                     rsp_done,
   output logic [$clog2(MAXRD):0]   outstanding,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     stall_err,
   output logic                     proto_err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned OW = $clog2(MAXRD) + 1;
   localparam int unsigned SW = $clog2(TMO + 1);

   logic [WID-1:0] r_mem [DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic [OW-1:0]  r_outstanding;
   logic [SW-1:0]  r_stall;
   logic           r_stall_err;
   logic           r_proto_err;

   logic [WID-1:0] w_msg;
   logic [WID-1:0] w_head;
   logic           w_head_rd;
   logic           w_present;
   logic           w_push;
   logic           w_pop;
   logic           w_rd_inc;
   logic           w_rd_dec;
   logic           w_ack_bad;
   logic           w_rsp_bad;
   logic [SW-1:0]  w_stall_nxt;
   logic           w_unused_ack;

   assign w_msg        = {req_data, req_size, req_addr, req_target, req_cmd};
   assign w_head       = r_mem[r_rptr];
   assign w_head_rd    = (w_head[1:0] == 2'd2);
   // A read at the head with no credit left holds the whole queue.
   assign w_present    = (r_count != '0) && !(w_head_rd && (r_outstanding == OW'(MAXRD)));
   assign req_ready    = (r_count < CW'(DEPTH));
   assign w_push       = req_valid && req_ready && (req_cmd != 2'd0);
   assign w_pop        = w_present && ack_out[0];
   assign w_rd_inc     = w_pop && w_head_rd;
   assign w_rd_dec     = rsp_done && (r_outstanding != '0);
   assign w_ack_bad    = ack_out[0] && !w_present;
   assign w_rsp_bad    = rsp_done && (r_outstanding == '0);
   assign w_unused_ack = &{1'b0, ack_out[2:1]};

   assign rou_out      = w_present ? w_head : '0;
   assign rou_out_seen = 1'b0;
   assign fifo_count   = r_count;
   assign outstanding  = r_outstanding;
   assign stall_err    = r_stall_err;
   assign proto_err    = r_proto_err;

   // Consecutive unacked presentation cycles, saturating at TMO.
   always_comb begin
      w_stall_nxt = '0;
      if (w_present && !ack_out[0]) begin
         w_stall_nxt = (r_stall == SW'(TMO)) ? r_stall : r_stall + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_msg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_stall       <= '0;
         r_stall_err   <= 1'b0;
         r_proto_err   <= 1'b0;
      end else if (softreset) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_stall       <= '0;
         r_stall_err   <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_rd_inc && !w_rd_dec) begin
            r_outstanding <= r_outstanding + OW'(1);
         end else if (!w_rd_inc && w_rd_dec) begin
            r_outstanding <= r_outstanding - OW'(1);
         end
         r_stall <= w_stall_nxt;
         if (w_stall_nxt == SW'(TMO)) begin
            r_stall_err <= 1'b1;
         end
         if (w_ack_bad || w_rsp_bad) begin
            r_proto_err <= 1'b1;
         end
      end
   end

endmodule
